// File: rtl/slc3m_mem_arbiter_pkg.sv
// Shared types and constants for the multi-core SLC3 SRAM arbiter.
package slc3m_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        READY,
        HOLD
    } arb_state_t;

    localparam int SLC3M_ADDR_W    = 20;
    localparam int SLC3M_DATA_W    = 16;
    localparam int SLC3M_NUM_CORES = 4;

    // $clog2(1) is 0, which would give a zero-width grant_id; keep at least one bit.
    function automatic int clog2_safe(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/slc3m_mem_arbiter_if.sv
// Bundle of per-core request lines and SRAM pins shared by the arbiter.
interface slc3m_mem_arbiter_if #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 20,
    parameter int DATA_W    = 16
);
    import slc3m_pkg::*;

    localparam int ID_W = clog2_safe(NUM_CORES);

    logic [NUM_CORES*ADDR_W-1:0] core_addr;
    logic [NUM_CORES*DATA_W-1:0] core_wdata;
    logic [NUM_CORES-1:0]        core_oe_n;
    logic [NUM_CORES-1:0]        core_we_n;
    logic [DATA_W-1:0]           core_rdata;
    logic [NUM_CORES-1:0]        mem_ready;
    logic [ADDR_W-1:0]           sram_addr;
    logic [DATA_W-1:0]           sram_wdata;
    logic [DATA_W-1:0]           sram_rdata;
    logic                        sram_ce_n;
    logic                        sram_oe_n;
    logic                        sram_we_n;
    logic                        grant_valid;
    logic [ID_W-1:0]             grant_id;

    // Arbiter side: consumes core requests and SRAM read data.
    modport slave (
        input  core_addr, core_wdata, core_oe_n, core_we_n, sram_rdata,
        output core_rdata, mem_ready, sram_addr, sram_wdata,
               sram_ce_n, sram_oe_n, sram_we_n, grant_valid, grant_id
    );

    // Core/SRAM side: drives requests and read data, observes the grant.
    modport master (
        output core_addr, core_wdata, core_oe_n, core_we_n, sram_rdata,
        input  core_rdata, mem_ready, sram_addr, sram_wdata,
               sram_ce_n, sram_oe_n, sram_we_n, grant_valid, grant_id
    );

endinterface

// File: rtl/slc3m_mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after the pointer.
module slc3m_rr_pick
    import slc3m_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int ID_W      = clog2_safe(NUM_CORES)
) (
    input  logic [NUM_CORES-1:0] i_req,
    input  logic [ID_W-1:0]      i_ptr,
    output logic                 o_any,
    output logic [ID_W-1:0]      o_idx
);

    logic [2*NUM_CORES-1:0] w_dbl;
    logic [NUM_CORES-1:0]   w_rot;

    // Rotate the doubled request vector so the pointer lands at bit 0, then take the lowest set bit.
    always_comb begin
        w_dbl = {i_req, i_req} >> i_ptr;
        w_rot = w_dbl[NUM_CORES-1:0];
        o_any = |i_req;
        o_idx = '0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                o_idx = ID_W'((int'(i_ptr) + k) % NUM_CORES);
            end
        end
    end

endmodule

// File: rtl/slc3m_mem_arbiter.sv
// Round-robin arbiter sharing one off-chip SRAM between several SLC3 cores.
module slc3m_mem_arbiter
    import slc3m_pkg::*;
#(
    parameter int NUM_CORES   = SLC3M_NUM_CORES,
    parameter int ADDR_W      = SLC3M_ADDR_W,
    parameter int DATA_W      = SLC3M_DATA_W,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    slc3m_mem_arbiter_if.slave   bus
);

    localparam int         ID_W     = clog2_safe(NUM_CORES);
    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    arb_state_t             r_state;
    logic [ID_W-1:0]        r_rr_ptr;
    logic [ID_W-1:0]        r_grant_id;
    logic [3:0]             r_cnt;
    logic [ADDR_W-1:0]      r_addr;
    logic [DATA_W-1:0]      r_wdata;
    logic                   r_is_write;
    logic [DATA_W-1:0]      r_rdata;
    logic [NUM_CORES-1:0]   r_mem_ready;
    logic                   r_ce_n;
    logic                   r_oe_n;
    logic                   r_we_n;
    logic                   r_valid;

    logic [NUM_CORES-1:0]   w_req;
    logic                   w_any;
    logic [ID_W-1:0]        w_idx;
    logic [ID_W-1:0]        w_next_ptr;
    logic [NUM_CORES-1:0]   w_ready_hot;

    assign w_req       = ~bus.core_oe_n | ~bus.core_we_n;
    assign w_ready_hot = NUM_CORES'(1) << r_grant_id;

    slc3m_rr_pick #(
        .NUM_CORES (NUM_CORES),
        .ID_W      (ID_W)
    ) u_pick (
        .i_req (w_req),
        .i_ptr (r_rr_ptr),
        .o_any (w_any),
        .o_idx (w_idx)
    );

    // Next round-robin start is the core after the one just served, wrapping at NUM_CORES.
    always_comb begin
        if (r_grant_id == ID_W'(NUM_CORES - 1)) begin
            w_next_ptr = '0;
        end else begin
            w_next_ptr = r_grant_id + 1'b1;
        end
    end

    // Access sequencer: grant, hold the SRAM for WAIT_CYCLES, pulse ready, then a hold cycle before re-arbitrating.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_grant_id  <= '0;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_is_write  <= 1'b0;
            r_rdata     <= '0;
            r_mem_ready <= '0;
            r_ce_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_we_n      <= 1'b1;
            r_valid     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_addr     <= bus.core_addr[int'(w_idx)*ADDR_W +: ADDR_W];
                        r_wdata    <= bus.core_wdata[int'(w_idx)*DATA_W +: DATA_W];
                        r_is_write <= ~bus.core_we_n[w_idx];
                        r_grant_id <= w_idx;
                        r_cnt      <= CNT_INIT;
                        r_ce_n     <= 1'b0;
                        r_oe_n     <= ~bus.core_we_n[w_idx];
                        r_we_n     <= bus.core_we_n[w_idx];
                        r_valid    <= 1'b1;
                        r_state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (r_cnt == '0) begin
                        r_mem_ready <= w_ready_hot;
                        if (!r_is_write) begin
                            r_rdata <= bus.sram_rdata;
                        end
                        r_state <= READY;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                READY: begin
                    r_mem_ready <= '0;
                    r_we_n      <= 1'b1;
                    r_state     <= HOLD;
                end
                HOLD: begin
                    r_rr_ptr <= w_next_ptr;
                    r_ce_n   <= 1'b1;
                    r_oe_n   <= 1'b1;
                    r_valid  <= 1'b0;
                    r_state  <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.core_rdata  = r_rdata;
    assign bus.mem_ready   = r_mem_ready;
    assign bus.sram_addr   = r_addr;
    assign bus.sram_wdata  = r_wdata;
    assign bus.sram_ce_n   = r_ce_n;
    assign bus.sram_oe_n   = r_oe_n;
    assign bus.sram_we_n   = r_we_n;
    assign bus.grant_valid = r_valid;
    assign bus.grant_id    = r_grant_id;

endmodule

// File: tb/tb_slc3m_mem_arbiter.sv
// Scoreboard bench for the SLC3 multi-core SRAM arbiter with a small SRAM model.
module tb_slc3m_mem_arbiter;

    localparam int NC = 4;
    localparam int AW = 20;
    localparam int DW = 16;
    localparam int WC = 2;

    typedef struct {
        int          core;
        bit          chkData;
        logic [15:0] data;
    } exp_t;

    logic Clk;
    logic Reset_n;

    exp_t        sbQ[$];
    int          readyCyc[$];
    int          nCompared = 0;
    int          nMismatched = 0;
    int          cyc = 0;
    logic [15:0] mem [256];
    logic [19:0] lastWrAddr = '0;
    logic [15:0] lastWrData = '0;

    slc3m_mem_arbiter_if #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW)) bus ();

    slc3m_mem_arbiter #(
        .NUM_CORES   (NC),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .WAIT_CYCLES (WC)
    ) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    // Free-running clock.
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // SRAM read port: data only while output-enabled, otherwise a recognisable filler.
    assign bus.sram_rdata = (bus.sram_oe_n == 1'b0) ? mem[bus.sram_addr[7:0]] : 16'hDEAD;

    // SRAM contents and write port: a write lands on the rising edge of WE while CE is low.
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h10] = 16'h1234;
        mem[8'h40] = 16'hC0A0;
        mem[8'h41] = 16'hC1A1;
        mem[8'h42] = 16'hC2A2;
        mem[8'h43] = 16'hC3A3;
        forever begin
            @(posedge bus.sram_we_n);
            if (bus.sram_ce_n === 1'b0) begin
                mem[bus.sram_addr[7:0]] = bus.sram_wdata;
                lastWrAddr = bus.sram_addr;
                lastWrData = bus.sram_wdata;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Monitor: every mem_ready pulse is matched against the next expected grant.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            cyc++;
            if (bus.mem_ready !== '0) begin
                readyCyc.push_back(cyc);
                if (sbQ.size() == 0) begin
                    nCompared++;
                    nMismatched++;
                    $display("[TB] FAIL unexpected_ready: got mem_ready=%b, required no pulse", bus.mem_ready);
                end else begin
                    e = sbQ.pop_front();
                    checkOutput("sb_mem_ready", 32'(bus.mem_ready), 32'(1) << e.core);
                    checkOutput("sb_grant_id", 32'(bus.grant_id), 32'(e.core));
                    if (e.chkData) checkOutput("sb_core_rdata", 32'(bus.core_rdata), 32'(e.data));
                end
            end
        end
    end

    task automatic pushExp(input int c, input bit chk, input logic [15:0] d);
        exp_t e;
        e.core = c;
        e.chkData = chk;
        e.data = d;
        sbQ.push_back(e);
    endtask

    task automatic driveCore(input int c, input int mode, input logic [19:0] a, input logic [15:0] d);
        bus.core_addr[c*AW +: AW]  = a;
        bus.core_wdata[c*DW +: DW] = d;
        bus.core_oe_n[c] = (mode == 1);
        bus.core_we_n[c] = (mode == 0);
    endtask

    task automatic releaseCore(input int c);
        bus.core_oe_n[c] = 1'b1;
        bus.core_we_n[c] = 1'b1;
    endtask

    // One isolated access (mode 0 read, 1 write, 2 both strobes), measuring latency and strobe widths.
    task automatic applyStimulus(input int c, input int mode, input logic [19:0] a, input logic [15:0] d,
                                 output int readyAt, output int oeLow, output int weLow, output int gid);
        readyAt = -1;
        oeLow = 0;
        weLow = 0;
        gid = -1;
        driveCore(c, mode, a, d);
        for (int i = 1; i <= 12; i++) begin
            @(negedge Clk);
            if (bus.sram_oe_n == 1'b0) oeLow++;
            if (bus.sram_we_n == 1'b0) weLow++;
            if (bus.mem_ready[c] && readyAt < 0) begin
                readyAt = i;
                gid = int'(bus.grant_id);
            end
            if (readyAt > 0 && i == readyAt + 1) releaseCore(c);
        end
        releaseCore(c);
    endtask

    // A core that keeps its strobe low until its own ready pulse, then drops it during the hold cycle.
    task automatic holdRequest(input int c, input logic [19:0] a);
        int gotReady;
        gotReady = 0;
        driveCore(c, 0, a, 16'h0000);
        for (int n = 0; n < 60; n++) begin
            @(negedge Clk);
            if (bus.mem_ready[c]) begin
                gotReady = 1;
                break;
            end
        end
        checkOutput($sformatf("core%0d_ready_seen", c), 32'(gotReady), 32'd1);
        @(negedge Clk);
        releaseCore(c);
    endtask

    // Directed sequence.
    initial begin
        int ra, oe, we, gid;
        Reset_n = 1'b0;
        bus.core_addr  = '0;
        bus.core_wdata = '0;
        bus.core_oe_n  = '1;
        bus.core_we_n  = '1;
        repeat (3) @(negedge Clk);
        checkOutput("rst_ce_n", 32'(bus.sram_ce_n), 32'd1);
        checkOutput("rst_oe_n", 32'(bus.sram_oe_n), 32'd1);
        checkOutput("rst_we_n", 32'(bus.sram_we_n), 32'd1);
        checkOutput("rst_mem_ready", 32'(bus.mem_ready), 32'd0);
        checkOutput("rst_grant_valid", 32'(bus.grant_valid), 32'd0);
        checkOutput("rst_core_rdata", 32'(bus.core_rdata), 32'd0);
        Reset_n = 1'b1;
        @(negedge Clk);

        // Single read by core 1.
        pushExp(1, 1'b1, 16'h1234);
        applyStimulus(1, 0, 20'h00010, 16'h0000, ra, oe, we, gid);
        checkOutput("rd_latency", 32'(ra), 32'd3);
        checkOutput("rd_oe_low_cycles", 32'(oe), 32'd4);
        checkOutput("rd_we_low_cycles", 32'(we), 32'd0);
        checkOutput("rd_grant_id", 32'(gid), 32'd1);
        checkOutput("rd_core_rdata", 32'(bus.core_rdata), 32'h1234);

        // Single write by core 2.
        pushExp(2, 1'b0, 16'h0000);
        applyStimulus(2, 1, 20'h00020, 16'hBEEF, ra, oe, we, gid);
        checkOutput("wr_we_low_cycles", 32'(we), 32'd3);
        checkOutput("wr_oe_low_cycles", 32'(oe), 32'd0);
        checkOutput("wr_sram_addr", 32'(lastWrAddr), 32'h00020);
        checkOutput("wr_sram_data", 32'(lastWrData), 32'hBEEF);
        checkOutput("wr_mem_content", 32'(mem[8'h20]), 32'hBEEF);
        checkOutput("wr_rdata_kept", 32'(bus.core_rdata), 32'h1234);

        // Both strobes low on core 3 is a write; pointer wraps back to core 0.
        pushExp(3, 1'b0, 16'h0000);
        applyStimulus(3, 2, 20'h00030, 16'h5A5A, ra, oe, we, gid);
        checkOutput("both_we_low_cycles", 32'(we), 32'd3);
        checkOutput("both_oe_low_cycles", 32'(oe), 32'd0);
        checkOutput("both_mem_content", 32'(mem[8'h30]), 32'h5A5A);

        // Four-way contention: grants 0,1,2,3 five cycles apart.
        readyCyc.delete();
        pushExp(0, 1'b1, 16'hC0A0);
        pushExp(1, 1'b1, 16'hC1A1);
        pushExp(2, 1'b1, 16'hC2A2);
        pushExp(3, 1'b1, 16'hC3A3);
        fork
            holdRequest(0, 20'h00040);
            holdRequest(1, 20'h00041);
            holdRequest(2, 20'h00042);
            holdRequest(3, 20'h00043);
        join
        checkOutput("cont_pulses", 32'(readyCyc.size()), 32'd4);
        if (readyCyc.size() == 4) begin
            for (int i = 1; i < 4; i++)
                checkOutput($sformatf("cont_spacing%0d", i), 32'(readyCyc[i] - readyCyc[i-1]), 32'd5);
        end
        @(negedge Clk);

        // Core 3 served, then cores 0 and 3 together: core 0 first.
        pushExp(3, 1'b1, 16'hC3A3);
        applyStimulus(3, 0, 20'h00043, 16'h0000, ra, oe, we, gid);
        pushExp(0, 1'b1, 16'hC0A0);
        pushExp(3, 1'b1, 16'hC3A3);
        fork
            holdRequest(0, 20'h00040);
            holdRequest(3, 20'h00043);
        join
        @(negedge Clk);

        // Core 1 served (pointer at 2), then cores 0 and 3 together: core 3 first.
        pushExp(1, 1'b1, 16'hC1A1);
        applyStimulus(1, 0, 20'h00041, 16'h0000, ra, oe, we, gid);
        pushExp(3, 1'b1, 16'hC3A3);
        pushExp(0, 1'b1, 16'hC0A0);
        fork
            holdRequest(0, 20'h00040);
            holdRequest(3, 20'h00043);
        join
        @(negedge Clk);

        // Core 2 served, leaving the pointer at 3 before the reset.
        pushExp(2, 1'b1, 16'hC2A2);
        applyStimulus(2, 0, 20'h00042, 16'h0000, ra, oe, we, gid);

        // Reset during core 1's access: strobes drop at once, no ready pulse.
        driveCore(1, 0, 20'h00041, 16'h0000);
        @(negedge Clk);
        checkOutput("mid_grant_valid", 32'(bus.grant_valid), 32'd1);
        Reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_ce_n", 32'(bus.sram_ce_n), 32'd1);
        checkOutput("mid_rst_oe_n", 32'(bus.sram_oe_n), 32'd1);
        checkOutput("mid_rst_we_n", 32'(bus.sram_we_n), 32'd1);
        checkOutput("mid_rst_mem_ready", 32'(bus.mem_ready), 32'd0);
        checkOutput("mid_rst_grant_valid", 32'(bus.grant_valid), 32'd0);
        releaseCore(1);
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);

        // After reset the pointer restarts at 0: cores 1 and 3 together give core 1 first.
        pushExp(1, 1'b1, 16'hC1A1);
        pushExp(3, 1'b1, 16'hC3A3);
        fork
            holdRequest(1, 20'h00041);
            holdRequest(3, 20'h00043);
        join
        repeat (3) @(negedge Clk);
        checkOutput("sb_drained", 32'(sbQ.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/slc3m_mem_arbiter.md
Name: slc3m_mem_arbiter

Overview:
Shares the single off-chip SRAM between NUM_CORES SLC3 cores in the multi-core SLC3 build. Each core's ISDU drives active-low Mem_OE/Mem_WE and waits on mem_ready, as in Fetch2, S25_1 and S23_2. The arbiter grants one core at a time in round-robin order and drives the SRAM pins. It returns read data and a one-cycle mem_ready pulse to the granted core only. It sits between the per-core datapaths and the SRAM pin interface.

Parameters:
NUM_CORES, 4, number of requesting cores (2..8)
ADDR_W, 20, SRAM address width
DATA_W, 16, word width
WAIT_CYCLES, 2, SRAM access cycles per transfer (1..15)

Ports:
Clk  in  1  system clock, rising edge
Reset_n  in  1  asynchronous, active-low reset
core_addr  in  NUM_CORES*ADDR_W  per-core MAR, core i at [i*ADDR_W +: ADDR_W]
core_wdata  in  NUM_CORES*DATA_W  per-core MDR write data
core_oe_n  in  NUM_CORES  per-core Mem_OE, active low
core_we_n  in  NUM_CORES  per-core Mem_WE, active low
core_rdata  out  DATA_W  captured read data, broadcast to all cores
mem_ready  out  NUM_CORES  one-hot completion pulse
sram_addr  out  ADDR_W  SRAM address
sram_wdata  out  DATA_W  SRAM write data; top level drives the tristate
sram_rdata  in  DATA_W  SRAM read data
sram_ce_n, sram_oe_n, sram_we_n  out  1 each  SRAM strobes, active low
grant_valid  out  1  an access is in progress
grant_id  out  $clog2(NUM_CORES)  index of the granted core

Behaviour:
- Clock and reset: one clock, Clk. Reset is asynchronous and active-low on Reset_n.
- Reset values: state IDLE, rr_ptr=0, all outputs 0, except sram_ce_n, sram_oe_n and sram_we_n, which reset to 1.
- Request definition: req[i] = ~core_oe_n[i] | ~core_we_n[i]. If both strobes are low, the access is a write.
- FSM states and transitions:
  - IDLE: if any req, pick the winner via round-robin starting at rr_ptr. On the edge, register addr, wdata, is_write and grant_id, and load cnt=WAIT_CYCLES-1. Go to ACCESS.
  - ACCESS: drive the SRAM from the registered values. If cnt==0, go to READY and capture sram_rdata into core_rdata on that edge. Otherwise decrement cnt.
  - READY: mem_ready[grant_id]=1 for exactly this cycle. Keep the SRAM strobes asserted. Go to HOLD.
  - HOLD: strobes stay asserted and core_rdata is held. This covers the core's Fetch3/S25_2 MDR latch and the S16 write tail. Set rr_ptr=(grant_id+1) mod NUM_CORES. Go to IDLE.
- Latency: a request sampled at edge k gives mem_ready high in cycle k+1+WAIT_CYCLES. No new grant is issued before cycle k+3+WAIT_CYCLES.
- SRAM strobes:
  - sram_ce_n=0 in ACCESS, READY and HOLD.
  - Reads: sram_oe_n=0 in those same states.
  - Writes: sram_we_n=0 in ACCESS and READY only, then 1 in HOLD, so address and data are stable at the WE rising edge.
  - In IDLE, all strobes are 1.
- Address and data: sram_addr and sram_wdata come only from registers and are stable for the whole access. They are not a combinational passthrough of core inputs.
- core_rdata: retains its last captured value until the next read completes. Writes leave it unchanged.
- Fairness: with every core requesting continuously, grants rotate 0,1,2,3,0,… No core waits more than NUM_CORES-1 accesses.
- Request dropped mid-access: the access completes anyway, and mem_ready still pulses. This is harmless because the core ignores it.
- Stale requests: a core whose strobe is still low in HOLD is not re-granted. IDLE samples only after HOLD, when the ISDU has already left Fetch3/S16.
- Halted/SYNC cores: they assert no strobes and are skipped without penalty.
- Reset mid-access: all registers and outputs return to reset values immediately (asynchronous). The SRAM strobes deassert. No mem_ready is produced.
- Out-of-range parameters: NUM_CORES=1 is legal, and rr_ptr stays 0.

Decomposition:
- Shared package slc3m_pkg contains:
  - typedef arb_state_t {IDLE, ACCESS, READY, HOLD}
  - localparams SLC3M_ADDR_W=20, SLC3M_DATA_W=16, SLC3M_NUM_CORES=4
  - function clog2_safe, for the grant_id width when NUM_CORES=1
- Sub-module slc3m_rr_pick: combinational round-robin priority encoder.
  - Inputs: req[NUM_CORES], ptr.
  - Outputs: any, idx.
  - Implementation: double-width rotate-and-find-first.

Test Plan:
- Single read: core 1 drives oe_n=0, addr=0x00010, SRAM model holds 0x1234 -> mem_ready=0010 in cycle k+3 (WAIT_CYCLES=2), core_rdata=0x1234, sram_oe_n low for 4 cycles, grant_id=1.
- Single write: core 2 drives we_n=0, addr=0x00020, wdata=0xBEEF -> SRAM model contains 0xBEEF. sram_we_n=0 for exactly 3 cycles, rising while addr and data are stable. core_rdata is unchanged.
- Contention: all four cores request at once and hold until their own mem_ready -> grant order 0,1,2,3. mem_ready pulses one-hot, 5 cycles apart. Each core reads its own distinct address value.
- Fairness after rotation: core 3 is served, then cores 0 and 3 request together -> core 0 is granted first, core 3 second.
- Reset mid-access: Reset_n pulled low during ACCESS for core 1 -> sram_ce_n, sram_oe_n and sram_we_n go to 1 asynchronously. mem_ready stays 0000. After release, a new core 1 request completes normally with grant_id=1 and rr_ptr restarting at 0.
- Integrated: two SLC3 cores fetch from a shared program, one of them spinning in SYNC -> the active core's Fetch2 and S25_1 each see exactly one mem_ready per access. No instruction is fetched twice.
